// File: rtl/rtc_timekeeper_if.sv
// Control and time-display bundle between the clock front panel logic and the RTC.
// The master drives run/set/alarm controls; the slave (timekeeper) returns the time fields.
interface rtc_timekeeper_if;
  logic       run;
  logic       set_en;
  logic [1:0] set_sel;
  logic       set_inc;
  logic       mode_12h;
  logic       alarm_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       pm;
  logic       tick_1hz;
  logic       alarm_hit;

  modport master (
    output run, set_en, set_sel, set_inc, mode_12h, alarm_en, alarm_hour, alarm_min,
    input  sec, min, hour, pm, tick_1hz, alarm_hit
  );

  modport slave (
    input  run, set_en, set_sel, set_inc, mode_12h, alarm_en, alarm_hour, alarm_min,
    output sec, min, hour, pm, tick_1hz, alarm_hit
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// HH:MM:SS time-of-day counter with 1 Hz prescaler, field-wise setting,
// 12/24 h display mapping and an hour:minute alarm.
module rtc_timekeeper #(
  parameter int TICK_DIV = 65536,
  parameter int DIV_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  rtc_timekeeper_if.slave   bus
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] presc;
  logic [5:0]       sec_q;
  logic [5:0]       min_q;
  logic [4:0]       hour_q;
  logic             tick_q;
  logic             alarm_q;

  logic             tick;
  logic             sec_wrap;
  logic             min_wrap;
  logic [5:0]       sec_inc;
  logic [5:0]       min_inc;
  logic [4:0]       hour_inc;
  logic [5:0]       min_next;
  logic [4:0]       hour_next;
  logic             alarm_match;
  logic [4:0]       hour_disp;

  // Per-field increments are shared by the tick carry chain and the set path.
  always_comb begin
    tick        = bus.run && !bus.set_en && (presc == PRESC_LAST);
    sec_wrap    = (sec_q == 6'd59);
    min_wrap    = (min_q == 6'd59);
    sec_inc     = sec_wrap ? 6'd0 : sec_q + 6'd1;
    min_inc     = min_wrap ? 6'd0 : min_q + 6'd1;
    hour_inc    = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    min_next    = sec_wrap ? min_inc : min_q;
    hour_next   = (sec_wrap && min_wrap) ? hour_inc : hour_q;
    alarm_match = bus.alarm_en && sec_wrap && (min_next == bus.alarm_min) &&
                  (hour_next == bus.alarm_hour);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      tick_q  <= tick;
      alarm_q <= tick && alarm_match;
      if (bus.set_en) begin
        presc <= '0;
        if (bus.set_inc) begin
          case (bus.set_sel)
            2'd0:    sec_q  <= sec_inc;
            2'd1:    min_q  <= min_inc;
            2'd2:    hour_q <= hour_inc;
            default: ;
          endcase
        end
      end else if (bus.run) begin
        if (tick) begin
          presc  <= '0;
          sec_q  <= sec_inc;
          min_q  <= min_next;
          hour_q <= hour_next;
        end else begin
          presc <= presc + DIV_W'(1);
        end
      end
    end
  end

  // Display hour is purely combinational so a mode change shows immediately.
  always_comb begin
    hour_disp = hour_q;
    if (bus.mode_12h) begin
      if (hour_q == 5'd0)
        hour_disp = 5'd12;
      else if (hour_q > 5'd12)
        hour_disp = hour_q - 5'd12;
    end
  end

  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.hour      = hour_disp;
  assign bus.pm        = (hour_q >= 5'd12);
  assign bus.tick_1hz  = tick_q;
  assign bus.alarm_hit = alarm_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomised and directed bench for rtc_timekeeper; the reference model tracks
// time as seconds-of-day and a prescaler count.
module tb_rtc_timekeeper;
  localparam int TICK_DIV = 4;
  localparam int DIV_W    = 2;

  logic clock;
  logic reset;
  rtc_timekeeper_if bus ();

  rtc_timekeeper #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;
  int m_t;
  int m_pre;
  bit m_tick;
  bit m_alarm;
  int alarm_seen;
  int tick_seen;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int dispHour();
    int h;
    h = m_t / 3600;
    if (!bus.mode_12h) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  function automatic void modelReset();
    m_t = 0; m_pre = 0; m_tick = 0; m_alarm = 0;
  endfunction

  // One clock edge of the reference: time as a seconds-of-day integer.
  function automatic void modelEdge();
    int s, m, h;
    m_tick = 0;
    m_alarm = 0;
    s = m_t % 60; m = (m_t / 60) % 60; h = m_t / 3600;
    if (bus.set_en) begin
      m_pre = 0;
      if (bus.set_inc) begin
        if (bus.set_sel == 2'd0) s = (s + 1) % 60;
        if (bus.set_sel == 2'd1) m = (m + 1) % 60;
        if (bus.set_sel == 2'd2) h = (h + 1) % 24;
        m_t = h * 3600 + m * 60 + s;
      end
    end else if (bus.run) begin
      if (m_pre == TICK_DIV - 1) begin
        m_pre  = 0;
        m_t    = (m_t + 1) % 86400;
        m_tick = 1;
        if (bus.alarm_en && bus.alarm_hour <= 23 && bus.alarm_min <= 59)
          m_alarm = (m_t == int'(bus.alarm_hour) * 3600 + int'(bus.alarm_min) * 60);
      end else begin
        m_pre++;
      end
    end
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".sec"},   int'(bus.sec),       m_t % 60);
    checkOutput({tag, ".min"},   int'(bus.min),       (m_t / 60) % 60);
    checkOutput({tag, ".hour"},  int'(bus.hour),      dispHour());
    checkOutput({tag, ".pm"},    int'(bus.pm),        int'(m_t >= 43200));
    checkOutput({tag, ".tick"},  int'(bus.tick_1hz),  int'(m_tick));
    checkOutput({tag, ".alarm"}, int'(bus.alarm_hit), int'(m_alarm));
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clock);
    modelEdge();
    #1;
    if (bus.alarm_hit) alarm_seen++;
    if (bus.tick_1hz) tick_seen++;
    compareAll(tag);
  endtask

  task automatic applyStimulus(input bit run, input bit set_en, input logic [1:0] sel,
                               input bit inc, input string tag);
    bus.run = run; bus.set_en = set_en; bus.set_sel = sel; bus.set_inc = inc;
    stepCycle(tag);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b0;
    modelReset();
    #1;
    compareAll(tag);
    reset = 1'b1;
  endtask

  task automatic setTime(input int h, input int m, input int s);
    for (int guard = 0; guard < 60 && (m_t % 60) != s; guard++) begin
      applyStimulus(bus.run, 1, 2'd0, 1, "set_sec");
      applyStimulus(bus.run, 1, 2'd0, 0, "set_sec");
    end
    for (int guard = 0; guard < 60 && ((m_t / 60) % 60) != m; guard++) begin
      applyStimulus(bus.run, 1, 2'd1, 1, "set_min");
      applyStimulus(bus.run, 1, 2'd1, 0, "set_min");
    end
    for (int guard = 0; guard < 24 && (m_t / 3600) != h; guard++) begin
      applyStimulus(bus.run, 1, 2'd2, 1, "set_hour");
      applyStimulus(bus.run, 1, 2'd2, 0, "set_hour");
    end
    bus.set_sel = 2'd3;
  endtask

  initial begin
    int target;
    vectors = 0; miscompares = 0; alarm_seen = 0; tick_seen = 0;
    reset = 1'b0;
    bus.run = 0; bus.set_en = 0; bus.set_sel = 2'd3; bus.set_inc = 0;
    bus.mode_12h = 1; bus.alarm_en = 0; bus.alarm_hour = 5'd31; bus.alarm_min = 6'd63;
    modelReset();
    #3;
    compareAll("reset12");
    checkOutput("reset_hour12", int'(bus.hour), 12);
    bus.mode_12h = 0;
    #1;
    compareAll("reset24");
    @(posedge clock); #1;
    reset = 1'b1;

    // Free-running count: one minute takes 240 cycles.
    for (int i = 0; i < 240; i++) applyStimulus(1, 0, 2'd3, 0, "run");
    checkOutput("one_minute_min", int'(bus.min), 1);
    checkOutput("one_minute_sec", int'(bus.sec), 0);

    // Midnight rollover.
    setTime(23, 59, 58);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 2'd3, 0, "midnight");
    checkOutput("midnight_hour", int'(bus.hour), 0);
    checkOutput("midnight_pm", int'(bus.pm), 0);

    // 12 h mapping at 12:00 and 13:00 with immediate mode changes.
    setTime(12, 0, 0);
    bus.mode_12h = 1; #1;
    compareAll("noon12");
    checkOutput("noon12_pm", int'(bus.pm), 1);
    setTime(13, 0, 0);
    #1;
    checkOutput("h13_12h", int'(bus.hour), 1);
    bus.mode_12h = 0; #1;
    checkOutput("h13_24h", int'(bus.hour), 13);
    bus.mode_12h = 1;

    // Alarm by tick fires once; alarm time reached by setting does not.
    bus.alarm_hour = 5'd7; bus.alarm_min = 6'd30; bus.alarm_en = 1;
    setTime(7, 29, 59);
    alarm_seen = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 2'd3, 0, "alarm_tick");
    checkOutput("alarm_count_tick", alarm_seen, 1);
    setTime(7, 29, 0);
    alarm_seen = 0;
    setTime(7, 30, 0);
    checkOutput("alarm_count_set", alarm_seen, 0);
    bus.alarm_en = 0;

    // 61 minute increments in set mode, then the first tick after leaving.
    doReset("reset_mid");
    tick_seen = 0;
    for (int i = 0; i < 61; i++) begin
      applyStimulus(1, 1, 2'd1, 1, "set61");
      applyStimulus(1, 1, 2'd1, 0, "set61");
    end
    checkOutput("set61_min", int'(bus.min), 1);
    checkOutput("set61_hour", int'(bus.hour), 12);
    checkOutput("set61_ticks", tick_seen, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 2'd3, 0, "post_set");
    checkOutput("post_set_no_tick", int'(bus.tick_1hz), 0);
    applyStimulus(1, 0, 2'd3, 0, "post_set");
    checkOutput("post_set_tick", int'(bus.tick_1hz), 1);

    // Freeze with prescaler at 2, then reset mid-count.
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 2'd3, 0, "pre2");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 2'd3, 0, "frozen");
    applyStimulus(1, 0, 2'd3, 0, "thaw");
    applyStimulus(1, 0, 2'd3, 0, "thaw");
    checkOutput("thaw_tick", int'(bus.tick_1hz), 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 2'd3, 0, "run2");
    doReset("reset_async");

    // Randomised episodes near a random (sometimes unreachable) alarm time.
    for (int ep = 0; ep < 25; ep++) begin
      bus.alarm_hour = 5'($urandom_range(0, 25));
      bus.alarm_min  = 6'($urandom_range(0, 61));
      bus.alarm_en   = 1'($urandom_range(0, 3) != 0);
      bus.mode_12h   = 1'($urandom_range(0, 1));
      target = (int'(bus.alarm_hour % 24) * 3600 + int'(bus.alarm_min % 60) * 60 + 86400
                - int'($urandom_range(1, 3))) % 86400;
      setTime(target / 3600, (target / 60) % 60, target % 60);
      for (int i = 0; i < 40; i++) begin
        bus.mode_12h = ($urandom_range(0, 9) == 0) ? ~bus.mode_12h : bus.mode_12h;
        applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
